// File: rtl/cpu_pkg.sv
// Shared datapath types and constants for the register-file slice.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_sel_t;

  // One bit wider than a register index so the last-index compare is exact.
  typedef logic [ADDR_W:0] clr_cnt_t;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_e;

  localparam clr_cnt_t CLR_LAST = clr_cnt_t'(NUM_REGS - 1);

endpackage

// File: rtl/wr_demux1to8.sv
// Register-select demultiplexer: turns a register index into a one-hot
// write strobe, all zero when the enable is low.
module wr_demux1to8
  import cpu_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] sel,
  output logic [NUM_REGS-1:0] strobe
);

  // Decode the selected index into a single strobe bit.
  always_comb begin
    // NOTE: every bit gets a default first so no path leaves strobe
    // unassigned, which would otherwise infer a latch.
    strobe = '0;
    if (en) begin
      strobe[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_demux_regfile.sv
// Bus destination register file: 8 x 16-bit registers written from the data
// bus through a valid/ready handshake, two combinational read ports, and a
// clear engine that zeroes one register per cycle.
module bus_demux_regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic [ADDR_W-1:0] rd_sel_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_sel_b,
  output logic [DATA_W-1:0] rd_data_b
);

  rf_state_e           state;
  rf_state_e           state_nxt;
  clr_cnt_t            clr_cnt;
  logic                run_q;
  word_t               regs [NUM_REGS];
  logic                wr_fire;
  logic                strobe_en;
  reg_sel_t            strobe_sel;
  word_t               wr_word;
  logic [NUM_REGS-1:0] strobe;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge.
    if (!rst_n) begin
      state <= RF_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Holds wr_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Next-state and handshake outputs; clr_req is ignored once clearing.
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    clr_busy  = 1'b0;
    unique case (state)
      RF_IDLE: begin
        wr_ready = run_q;
        if (clr_req) begin
          state_nxt = RF_CLEAR;
        end
      end
      RF_CLEAR: begin
        clr_busy = 1'b1;
        if (clr_cnt == CLR_LAST) begin
          state_nxt = RF_IDLE;
        end
      end
      default: state_nxt = RF_IDLE;
    endcase
  end

  // Sweep index: walks 0..NUM_REGS-1 while clearing, parked at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
    end else if (state == RF_CLEAR && clr_cnt != CLR_LAST) begin
      clr_cnt <= clr_cnt + clr_cnt_t'(1);
    end else begin
      clr_cnt <= '0;
    end
  end

  // The demux is shared: the clear sweep owns it while busy, the bus
  // otherwise. Writes cannot fire while busy because wr_ready is low.
  assign wr_fire    = wr_valid & wr_ready;
  assign strobe_en  = clr_busy | wr_fire;
  assign strobe_sel = clr_busy ? clr_cnt[ADDR_W-1:0] : wr_sel;
  assign wr_word    = clr_busy ? '0 : wr_data;

  wr_demux1to8 u_demux (
    .en     (strobe_en),
    .sel    (strobe_sel),
    .strobe (strobe)
  );

  // Register storage: each register loads the shared write word on its strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the array is reset because an aborted clear must still leave
    // every register at zero; this costs a reset pin per storage bit.
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (strobe[i]) begin
          regs[i] <= wr_word;
        end
      end
    end
  end

  // Combinational read ports; no bypass of a same-cycle write.
  assign rd_data_a = regs[rd_sel_a];
  assign rd_data_b = regs[rd_sel_b];

endmodule
